// File: rtl/optrx_pkg.sv
// Shared types and default constants for the optical receive deframer.
//   optrx_state_e : alignment FSM states
//   DEF_*         : default parameter values
//   FRAME_W       : default frame length (header + payload bits)
package optrx_pkg;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } optrx_state_e;

    localparam int unsigned DEF_DATA_W     = 16;
    localparam int unsigned DEF_HDR_W      = 4;
    localparam logic [3:0]  DEF_SYNC_HDR   = 4'b1010;
    localparam int unsigned DEF_LOCK_CNT   = 3;
    localparam int unsigned DEF_UNLOCK_CNT = 4;
    localparam int unsigned DEF_FIFO_DEPTH = 4;

    // Bits per frame for a given header/payload split.
    function automatic int unsigned frame_len(input int unsigned hdr_w, input int unsigned data_w);
        return hdr_w + data_w;
    endfunction

    localparam int unsigned FRAME_W = frame_len(DEF_HDR_W, DEF_DATA_W);

endpackage

// File: rtl/optrx_word_fifo.sv
// Synchronous word FIFO for deframed payloads.
//   push/push_data : write request; accepted when not full, or when full
//                    and a pop happens in the same cycle
//   pop            : read request; ignored while empty
//   rd_data        : head-of-queue word (holds while empty)
//   not_empty      : at least one word buffered
//   full           : DEPTH words buffered
module optrx_word_fifo #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] rd_data,
    output logic              not_empty,
    output logic              full
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic              pop_ok;
    logic              push_ok;

    assign pop_ok    = pop && (count_q != '0);
    assign full      = (count_q == CNT_W'(DEPTH));
    assign push_ok   = push && (!full || pop_ok);
    assign not_empty = (count_q != '0);
    assign rd_data   = mem[rd_ptr_q];

    // Storage and pointers; DEPTH is a power of two so pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push_ok) begin
                mem[wr_ptr_q] <= push_data;
                wr_ptr_q      <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            unique case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/optical_rx_deframer.sv
// Frame-alignment and deserialization of the sliced optical receive stream.
//   clk, rst_n      : clock, synchronous active-low reset
//   rx_bit(_valid)  : sliced bit, MSB-first, qualified by valid
//   out_data/valid/ready : payload word stream to downstream logic
//   locked          : frame lock status
//   overflow        : sticky word-dropped flag, cleared by clear_overflow
//   hdr_err_cnt     : saturating header mismatch count
module optical_rx_deframer
    import optrx_pkg::*;
#(
    parameter int unsigned       DATA_W     = DEF_DATA_W,
    parameter int unsigned       HDR_W      = DEF_HDR_W,
    parameter logic [HDR_W-1:0]  SYNC_HDR   = DEF_SYNC_HDR,
    parameter int unsigned       LOCK_CNT   = DEF_LOCK_CNT,
    parameter int unsigned       UNLOCK_CNT = DEF_UNLOCK_CNT,
    parameter int unsigned       FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_bit,
    input  logic              rx_bit_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              locked,
    output logic              overflow,
    input  logic              clear_overflow,
    output logic [7:0]        hdr_err_cnt
);

    localparam int unsigned FRM_W  = frame_len(HDR_W, DATA_W);
    localparam int unsigned POS_W  = $clog2(FRM_W);
    localparam int unsigned GOOD_W = $clog2(LOCK_CNT + 1);
    localparam int unsigned BAD_W  = $clog2(UNLOCK_CNT + 1);

    optrx_state_e      state_q, state_d;
    logic [POS_W-1:0]  pos_q, pos_d;
    logic [HDR_W-1:0]  hdr_sr_q, hdr_sr_d, hdr_next;
    logic [DATA_W-1:0] data_sr_q, data_sr_d, data_next;
    logic [GOOD_W-1:0] good_q, good_d;
    logic [BAD_W-1:0]  bad_q, bad_d;
    logic              emit_q, emit_d;
    logic [7:0]        err_q, err_d;
    logic              overflow_d;
    logic              err_inc;
    logic              hdr_match;
    logic              push;
    logic              fifo_full;
    logic              drop;

    assign hdr_next    = {hdr_sr_q[HDR_W-2:0], rx_bit};
    assign data_next   = {data_sr_q[DATA_W-2:0], rx_bit};
    assign hdr_match   = (hdr_next == SYNC_HDR);
    assign hdr_err_cnt = err_q;

    // Both shift registers run on every accepted bit; header is examined when
    // the last header bit arrives, payload when the last payload bit arrives.
    always_comb begin
        state_d   = state_q;
        pos_d     = pos_q;
        hdr_sr_d  = hdr_sr_q;
        data_sr_d = data_sr_q;
        good_d    = good_q;
        bad_d     = bad_q;
        emit_d    = emit_q;
        err_inc   = 1'b0;
        push      = 1'b0;

        if (rx_bit_valid) begin
            hdr_sr_d  = hdr_next;
            data_sr_d = data_next;
            pos_d     = (pos_q == POS_W'(FRM_W - 1)) ? '0 : pos_q + POS_W'(1);

            unique case (state_q)
                HUNT: begin
                    pos_d = pos_q;
                    if (hdr_match) begin
                        pos_d  = POS_W'(HDR_W);
                        good_d = GOOD_W'(1);
                        bad_d  = '0;
                        if (LOCK_CNT <= 1) begin
                            state_d = LOCKED;
                            emit_d  = 1'b1;
                        end else begin
                            state_d = VERIFY;
                        end
                    end
                end
                VERIFY: begin
                    if (pos_q == POS_W'(HDR_W - 1)) begin
                        if (!hdr_match) begin
                            state_d = HUNT;
                            good_d  = '0;
                            err_inc = 1'b1;
                        end else if (good_q == GOOD_W'(LOCK_CNT - 1)) begin
                            state_d = LOCKED;
                            good_d  = '0;
                            bad_d   = '0;
                            emit_d  = 1'b1;
                        end else begin
                            good_d = good_q + GOOD_W'(1);
                        end
                    end
                end
                LOCKED: begin
                    if (pos_q == POS_W'(HDR_W - 1)) begin
                        if (hdr_match) begin
                            bad_d  = '0;
                            emit_d = 1'b1;
                        end else begin
                            err_inc = 1'b1;
                            emit_d  = 1'b0;
                            if (bad_q == BAD_W'(UNLOCK_CNT - 1)) begin
                                state_d = HUNT;
                                bad_d   = '0;
                            end else begin
                                bad_d = bad_q + BAD_W'(1);
                            end
                        end
                    end
                    if (pos_q == POS_W'(FRM_W - 1) && emit_q) begin
                        push = 1'b1;
                    end
                end
                default: state_d = HUNT;
            endcase
        end

        err_d = (err_inc && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
    end

    // A full FIFO only drops when nothing leaves in the same cycle.
    assign drop       = push && fifo_full && !(out_valid && out_ready);
    assign overflow_d = drop ? 1'b1 : (clear_overflow ? 1'b0 : overflow);

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= HUNT;
            pos_q     <= '0;
            hdr_sr_q  <= '0;
            data_sr_q <= '0;
            good_q    <= '0;
            bad_q     <= '0;
            emit_q    <= 1'b0;
            err_q     <= '0;
            locked    <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            state_q   <= state_d;
            pos_q     <= pos_d;
            hdr_sr_q  <= hdr_sr_d;
            data_sr_q <= data_sr_d;
            good_q    <= good_d;
            bad_q     <= bad_d;
            emit_q    <= emit_d;
            err_q     <= err_d;
            locked    <= (state_d == LOCKED);
            overflow  <= overflow_d;
        end
    end

    optrx_word_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (data_next),
        .pop       (out_ready),
        .rd_data   (out_data),
        .not_empty (out_valid),
        .full      (fifo_full)
    );

endmodule

// File: tb/tb_optical_rx_deframer.sv
module tb_optical_rx_deframer;

    localparam int HDR  = 4;
    localparam int DATW = 16;
    localparam int FRM  = HDR + DATW;
    localparam int SYNC = 4'b1010;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx_bit = 1'b0;
    logic        rx_bit_valid = 1'b0;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        locked;
    logic        overflow;
    logic        clear_overflow = 1'b0;
    logic [7:0]  hdr_err_cnt;

    int checks = 0;
    int failures = 0;

    // reference model: frame-level view of the accepted bit stream
    int          m_mode;   // 0 hunting, 1 verifying, 2 locked
    int          m_pos, m_good, m_bad, m_err, m_hist, m_word;
    bit          m_emit, m_ovf;
    logic [15:0] m_q[$];
    logic [15:0] got[$];
    bit          tb_ready;
    bit          rand_mode;

    always #5 clk = ~clk;

    optical_rx_deframer dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .rx_bit         (rx_bit),
        .rx_bit_valid   (rx_bit_valid),
        .out_data       (out_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .locked         (locked),
        .overflow       (overflow),
        .clear_overflow (clear_overflow),
        .hdr_err_cnt    (hdr_err_cnt)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_pos = 0; m_good = 0; m_bad = 0; m_err = 0;
        m_hist = 0; m_word = 0; m_emit = 0; m_ovf = 0;
        m_q.delete();
    endtask

    task automatic model_header();
        bit ok = (m_hist == SYNC);
        if (m_mode == 1) begin
            if (!ok) begin
                m_mode = 0; m_good = 0;
                if (m_err < 255) m_err++;
            end else begin
                m_good++;
                if (m_good == 3) begin m_mode = 2; m_emit = 1; m_bad = 0; end
            end
        end else begin
            if (ok) begin
                m_bad = 0; m_emit = 1;
            end else begin
                m_bad++; m_emit = 0;
                if (m_err < 255) m_err++;
                if (m_bad == 4) begin m_mode = 0; m_bad = 0; m_good = 0; end
            end
        end
    endtask

    task automatic model_edge(input bit b, input bit v, input bit rdy, input bit clr, input bit rst);
        int  sz;
        bit  pop, push;
        int  cur;
        if (!rst) begin
            model_reset();
            return;
        end
        sz = m_q.size();
        pop = (sz > 0) && rdy;
        push = 0;
        if (v) begin
            m_hist = ((m_hist << 1) | int'(b)) & 15;
            m_word = ((m_word << 1) | int'(b)) & 16'hFFFF;
            if (m_mode == 0) begin
                if (m_hist == SYNC) begin m_mode = 1; m_good = 1; m_pos = HDR; end
            end else begin
                cur = m_pos;
                m_pos = (m_pos + 1) % FRM;
                if (cur == HDR - 1) model_header();
                else if (cur == FRM - 1 && m_mode == 2 && m_emit) push = 1;
            end
        end
        if (pop) void'(m_q.pop_front());
        if (push && sz == 4 && !pop) m_ovf = 1;
        else begin
            if (push) m_q.push_back(16'(m_word));
            if (clr) m_ovf = 0;
        end
    endtask

    // one clock: drive, advance, update model, compare all outputs
    task automatic step(input bit b, input bit v, input bit rdy, input bit clr, input bit rst);
        rx_bit = b; rx_bit_valid = v; out_ready = rdy; clear_overflow = clr; rst_n = rst;
        if (rst && rdy && out_valid) got.push_back(out_data);
        @(posedge clk);
        model_edge(b, v, rdy, clr, rst);
        #1;
        check("out_valid", 32'(out_valid), 32'(m_q.size() > 0));
        check("locked", 32'(locked), 32'(m_mode == 2));
        check("overflow", 32'(overflow), 32'(m_ovf));
        check("hdr_err_cnt", 32'(hdr_err_cnt), 32'(m_err));
        if (m_q.size() > 0) check("out_data", 32'(out_data), 32'(m_q[0]));
    endtask

    task automatic send_bit(input bit b, input int gap);
        bit rdy, clr;
        for (int i = 0; i < gap; i++) begin
            rdy = rand_mode ? ($urandom_range(0, 3) != 0) : tb_ready;
            step(1'($urandom), 1'b0, rdy, 1'b0, 1'b1);
        end
        rdy = rand_mode ? ($urandom_range(0, 3) != 0) : tb_ready;
        clr = rand_mode ? ($urandom_range(0, 15) == 0) : 1'b0;
        step(b, 1'b1, rdy, clr, 1'b1);
    endtask

    task automatic send_bits(input logic [31:0] val, input int n, input int gap);
        for (int i = n - 1; i >= 0; i--) send_bit(val[i], gap);
    endtask

    task automatic send_frame(input logic [3:0] hdr, input logic [15:0] word, input int gap);
        send_bits(32'(hdr), HDR, gap);
        send_bits(32'(word), DATW, gap);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, tb_ready, 1'b0, 1'b1);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) step(1'($urandom), 1'($urandom), 1'($urandom), 1'b0, 1'b0);
    endtask

    // scenario 2 shape: acquire with 0x1111, 0x2222, 0x1234
    task automatic acquire(input int gap);
        got.delete();
        tb_ready = 1;
        send_bits(0, 10, gap);
        send_frame(4'b1010, 16'h1111, gap);
        send_frame(4'b1010, 16'h2222, gap);
        send_bits(32'b101, 3, gap);
        check("lock_before_hdr3", 32'(locked), 0);
        send_bits(0, 1, gap);
        check("lock_after_hdr3", 32'(locked), 1);
        send_bits(32'h1234, DATW, gap);
        idle(3);
        check("acq_count", 32'(got.size()), 1);
        if (got.size() > 0) check("acq_word", 32'(got[0]), 32'h1234);
        check("acq_err", 32'(hdr_err_cnt), 0);
    endtask

    initial begin
        model_reset();
        tb_ready = 0;
        rand_mode = 0;

        // 1: reset with active-looking inputs
        do_reset(3);
        check("rst_valid", 32'(out_valid), 0);
        check("rst_locked", 32'(locked), 0);
        check("rst_err", 32'(hdr_err_cnt), 0);

        // 2: acquisition
        acquire(0);

        // 3: backpressure and overflow
        tb_ready = 0;
        got.delete();
        for (int i = 1; i <= 5; i++) send_frame(4'b1010, 16'hA000 + 16'(i), 0);
        check("bp_overflow", 32'(overflow), 1);
        tb_ready = 1;
        idle(6);
        check("bp_count", 32'(got.size()), 4);
        for (int i = 0; i < 4 && i < got.size(); i++) check("bp_order", 32'(got[i]), 32'hA001 + 32'(i));
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        check("ovf_clear", 32'(overflow), 0);

        // 4: bad headers, recovery, then loss of lock
        got.delete();
        for (int i = 0; i < 3; i++) send_frame(4'b0000, 16'(32'h5A5A + i), 0);
        send_frame(4'b1010, 16'hBEEF, 0);
        idle(3);
        check("bad_locked", 32'(locked), 1);
        check("bad_count", 32'(got.size()), 1);
        if (got.size() > 0) check("bad_word", 32'(got[0]), 32'hBEEF);
        check("bad_err3", 32'(hdr_err_cnt), 3);
        for (int i = 0; i < 3; i++) send_frame(4'b0000, 16'h0000, 0);
        send_bits(0, HDR, 0);
        check("unlock", 32'(locked), 0);
        check("unlock_err7", 32'(hdr_err_cnt), 7);
        send_bits(0, DATW, 0);

        // 5: gapped input, valid every 3rd cycle
        do_reset(1);
        acquire(2);

        // 6: reset mid-payload with two words buffered
        tb_ready = 0;
        send_frame(4'b1010, 16'hC001, 0);
        send_frame(4'b1010, 16'hC002, 0);
        send_bits(32'b1010, HDR, 0);
        send_bits(32'h1F, 5, 0);
        check("pre_rst_valid", 32'(out_valid), 1);
        do_reset(1);
        check("mid_rst_valid", 32'(out_valid), 0);
        check("mid_rst_locked", 32'(locked), 0);
        acquire(0);

        // 7: randomized frames, slips, gaps, backpressure, clears
        rand_mode = 1;
        for (int f = 0; f < 350; f++) begin
            logic [3:0] h;
            h = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b1010;
            if ($urandom_range(0, 19) == 0) send_bits(32'($urandom), $urandom_range(1, 3), 0);
            send_frame(h, 16'($urandom), $urandom_range(0, 1));
        end
        rand_mode = 0;
        tb_ready = 1;
        idle(8);

        // error counter saturation: hunt match followed by a failed verify
        for (int i = 0; i < 260; i++) begin
            send_frame(4'b1010, 16'h0000, 0);
            send_frame(4'b0000, 16'h0000, 0);
        end
        check("err_saturate", 32'(hdr_err_cnt), 255);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/optical_rx_deframer.md
Name: optical_rx_deframer

Overview:
Receive-side counterpart of the modulator driver. It takes the sliced bit stream from the receiver ring's photodetector/comparator and acquires frame alignment on a fixed header pattern. Once aligned, it deserializes each frame's payload into parallel words and hands them to downstream logic through a valid/ready interface with a small buffer. It sits after the receiver ring and drop path in the cell-chip electrical back-end.

Parameters:
- DATA_W, 16: payload bits per frame.
- HDR_W, 4: header bits per frame.
- SYNC_HDR, 4'b1010: required header value.
- LOCK_CNT, 3: consecutive good headers needed to declare lock (including the first hunt match).
- UNLOCK_CNT, 4: consecutive bad headers while locked that cause loss of lock.
- FIFO_DEPTH, 4: output buffer entries. Must be a power of 2 and at least 2.

Ports:
- clk, in, 1: clock.
- rst_n, in, 1: synchronous active-low reset.
- rx_bit, in, 1: sliced receiver bit.
- rx_bit_valid, in, 1: rx_bit is valid this cycle. Sampled only when high.
- out_data, out, DATA_W: deserialized payload word.
- out_valid, out, 1: out_data valid.
- out_ready, in, 1: downstream accepts the word.
- locked, out, 1: frame lock achieved.
- overflow, out, 1: sticky flag; a word was dropped because the FIFO was full.
- clear_overflow, in, 1: clears overflow.
- hdr_err_cnt, out, 8: saturating count of header mismatches.

Behaviour:
- Reset (rst_n low at a clk edge):
  - state=HUNT; all counters and the shift register cleared; FIFO emptied.
  - out_valid=0, out_data=0, locked=0, overflow=0, hdr_err_cnt=0.
  - Reset mid-frame discards the partial word and all buffered words.
- Bit order and framing:
  - Bits are MSB-first.
  - Frame = HDR_W header bits followed by DATA_W payload bits.
  - A position counter runs 0..HDR_W+DATA_W-1 and advances only on rx_bit_valid. No progress occurs on idle cycles.
- HUNT:
  - HDR_W-bit shift register, compared after every accepted bit.
  - On a match: go to VERIFY with good_cnt=1 and position=HDR_W (next bit is payload bit 0).
  - Mismatches in HUNT do not count as errors.
- VERIFY:
  - Payload bits are shifted but discarded.
  - At the end of each header: a match increments good_cnt; when good_cnt reaches LOCK_CNT, go to LOCKED.
  - A mismatch returns to HUNT, clears good_cnt and increments hdr_err_cnt.
- LOCKED:
  - locked=1 (registered; high from the cycle after the locking header's last bit).
  - Good header: bad_cnt=0, and the following payload is emitted.
  - Bad header: bad_cnt+1, hdr_err_cnt+1, and the following payload is dropped.
  - When bad_cnt reaches UNLOCK_CNT: go to HUNT and locked=0 on the next cycle. Buffered words are retained and remain deliverable.
- Push timing:
  - A payload word is pushed on the cycle its last bit is accepted.
  - out_valid is asserted at the earliest on the following cycle (1-cycle latency).
- FIFO:
  - Pops when out_valid && out_ready. Order is preserved.
  - A push while full is accepted only if a pop occurs in the same cycle.
  - Otherwise the word is dropped and overflow is set.
  - If overflow is set and cleared in the same cycle, set wins.
- hdr_err_cnt saturates at 255. It is cleared only by reset.
- out_data holds its value while out_valid=0. It is a don't-care for checking.

Decomposition:
- optrx_pkg holds:
  - the state enum (HUNT, VERIFY, LOCKED);
  - default parameter constants;
  - the HDR_W+DATA_W frame-length localparam.
- One sub-module, optrx_word_fifo: a synchronous FIFO with push/pop/full/empty and a simultaneous push+pop-when-full rule.
- The FSM, shift register and counters live in the top module.

Test Plan:
1. Reset: hold rst_n=0 for 3 cycles while toggling rx_bit/rx_bit_valid -> out_valid=0, locked=0, overflow=0, hdr_err_cnt=0.
2. Acquire: send 10 zero bits, then 3 frames with header 1010 and payloads 0x1111, 0x2222, 0x1234 (continuous valid) -> locked rises one cycle after the 3rd header's last bit; the only word out is 0x1234; hdr_err_cnt=0.
3. Backpressure: while locked with out_ready=0, send 5 good frames 0xA001..0xA005 -> 4 words buffered, 0xA005 dropped, overflow=1. Then set out_ready=1 -> 0xA001..0xA004 delivered in order. Pulse clear_overflow -> overflow=0.
4. Loss of lock: while locked, send 3 frames with header 0000, then 1 good frame 0xBEEF -> locked stays 1; only 0xBEEF is emitted; hdr_err_cnt=3. Then send 4 bad headers -> locked=0 one cycle after the 4th bad header; hdr_err_cnt=7.
5. Gapped input: repeat scenario 2 with rx_bit_valid high every 3rd cycle -> identical output word sequence and lock behaviour.
6. Reset mid-operation: locked with 2 words buffered, assert rst_n=0 mid-payload for 1 cycle -> FIFO empty, state HUNT, locked=0. Reacquisition then behaves as in scenario 2.
